sqrt_seq: RTL and testbench

- Parametrised, multi-cycle fixed-point square-root unit: floor(sqrt(din · 4^FRAC_W)), plus remainder and optional round-to-nearest.
- Computes one result bit per clock (restoring digit-by-digit method), so one small datapath serves any width.
- Sits between sensor/weight-conversion logic and the control FSMs in the baggage-drop datapath; start/done handshake.

---
 rtl/sqrt_pkg.sv | 27 ++
 rtl/sqrt_step.sv | 29 ++
 rtl/sqrt_seq.sv | 120 ++++++++++++
 tb/tb_sqrt_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential square-root unit.
package sqrt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } sqrt_state_t;

   // Radicand width: integer bits plus doubled fraction, padded up to an even count.
   function automatic int unsigned calc_rw(input int unsigned in_w, input int unsigned frac_w);
      int unsigned s;
      s = in_w + 2 * frac_w;
      return s + (s % 2);
   endfunction

   // Result width is half the padded radicand width.
   function automatic int unsigned calc_out_w(input int unsigned in_w, input int unsigned frac_w);
      return calc_rw(in_w, frac_w) / 2;
   endfunction

   // Bit counter width; at least one bit so a single-iteration variant still has a counter.
   function automatic int unsigned calc_cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: bring down two radicand bits, try to subtract (4q+1).
module sqrt_step #(
   parameter int unsigned OUT_W = 12
) (
   input  logic [OUT_W+1:0] rem_part,
   input  logic [OUT_W-1:0] q,
   input  logic [1:0]       next2,
   output logic [OUT_W+1:0] rem_part_new,
   output logic [OUT_W-1:0] q_new
);

   localparam int unsigned TW = OUT_W + 4;

   logic [TW-1:0]      acc;
   logic [TW-1:0]      sub;
   logic               ge;
   logic [OUT_W+1:0]   diff;

   // Trial subtract; an accepted remainder is at most 2q so the low bits carry the full result.
   always_comb begin
      acc          = {rem_part, next2};
      sub          = {2'b00, q, 2'b01};
      ge           = (acc >= sub);
      diff         = acc[OUT_W+1:0] - sub[OUT_W+1:0];
      rem_part_new = ge ? diff : acc[OUT_W+1:0];
      q_new        = OUT_W'({q, ge});
   end

endmodule

// File: rtl/sqrt_seq.sv
// Multi-cycle fixed-point square root, one result bit per clock, with optional rounding.
module sqrt_seq
   import sqrt_pkg::*;
#(
   parameter int unsigned IN_W   = 8,
   parameter int unsigned FRAC_W = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              round_en,
   input  logic [IN_W-1:0]                   din,
   output logic                              busy,
   output logic                              done,
   output logic [calc_out_w(IN_W, FRAC_W)-1:0] root,
   output logic [calc_out_w(IN_W, FRAC_W):0]   rem
);

   localparam int unsigned RW    = calc_rw(IN_W, FRAC_W);
   localparam int unsigned OUT_W = calc_out_w(IN_W, FRAC_W);
   localparam int unsigned N     = OUT_W;
   localparam int unsigned CNT_W = calc_cnt_w(N);

   sqrt_state_t         state, state_nxt;
   logic [RW-1:0]       rad, rad_nxt;
   logic [OUT_W+1:0]    rem_part, rem_part_nxt;
   logic [OUT_W-1:0]    q, q_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                rnd, rnd_nxt;
   logic                busy_nxt, done_nxt;
   logic [OUT_W-1:0]    root_nxt;
   logic [OUT_W:0]      rem_nxt;
   logic [OUT_W+1:0]    step_rem;
   logic [OUT_W-1:0]    step_q;

   sqrt_step #(.OUT_W(OUT_W)) u_step (
      .rem_part     (rem_part),
      .q            (q),
      .next2        (rad[RW-1 -: 2]),
      .rem_part_new (step_rem),
      .q_new        (step_q)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rad      <= '0;
         rem_part <= '0;
         q        <= '0;
         cnt      <= '0;
         rnd      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         root     <= '0;
         rem      <= '0;
      end else begin
         state    <= state_nxt;
         rad      <= rad_nxt;
         rem_part <= rem_part_nxt;
         q        <= q_nxt;
         cnt      <= cnt_nxt;
         rnd      <= rnd_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         root     <= root_nxt;
         rem      <= rem_nxt;
      end
   end

   // Next-state and next-register logic; everything holds unless a state says otherwise.
   always_comb begin
      state_nxt    = state;
      rad_nxt      = rad;
      rem_part_nxt = rem_part;
      q_nxt        = q;
      cnt_nxt      = cnt;
      rnd_nxt      = rnd;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      root_nxt     = root;
      rem_nxt      = rem;
      case (state)
         ST_IDLE: begin
            if (start) begin
               rad_nxt      = RW'(din) << (2 * FRAC_W);
               rnd_nxt      = round_en;
               rem_part_nxt = '0;
               q_nxt        = '0;
               cnt_nxt      = CNT_W'(N - 1);
               busy_nxt     = 1'b1;
               state_nxt    = ST_RUN;
            end
         end
         ST_RUN: begin
            rad_nxt      = rad << 2;
            rem_part_nxt = step_rem;
            q_nxt        = step_q;
            if (cnt == '0) begin
               busy_nxt  = 1'b0;
               state_nxt = ST_FIN;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_FIN: begin
            // Round up only when remainder exceeds q; an all-ones q saturates instead of wrapping.
            if (rnd && (rem_part > (OUT_W+2)'(q)) && !(&q))
               root_nxt = q + OUT_W'(1);
            else
               root_nxt = q;
            rem_nxt   = rem_part[OUT_W:0];
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed self-checking bench for sqrt_seq at default widths and with FRAC_W=0.
module tb_sqrt_seq;

   logic        clk;
   logic        rst_n;

   logic        start8, rnd8;
   logic [7:0]  din8;
   logic        busy8, done8;
   logic [11:0] root8;
   logic [12:0] rem8;

   logic        start0, rnd0;
   logic [7:0]  din0;
   logic        busy0, done0;
   logic [3:0]  root0;
   logic [4:0]  rem0;

   int checks = 0;
   int errors = 0;

   sqrt_seq #(.IN_W(8), .FRAC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .round_en(rnd8), .din(din8),
      .busy(busy8), .done(done8), .root(root8), .rem(rem8)
   );

   sqrt_seq #(.IN_W(8), .FRAC_W(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .round_en(rnd0), .din(din0),
      .busy(busy0), .done(done0), .root(root0), .rem(rem0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue a one-cycle start; returns at the falling edge right after the accepting edge.
   task automatic start_op(input bit sel0, input logic [7:0] d, input logic r);
      @(negedge clk);
      if (sel0) begin din0 = d; rnd0 = r; start0 = 1'b1; end
      else      begin din8 = d; rnd8 = r; start8 = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      start8 = 1'b0;
   endtask

   // Count edges until done (or -1 on timeout) and busy-high samples including the first one.
   task automatic wait_done(input bit sel0, output int edges, output int bcnt);
      edges = -1;
      bcnt  = sel0 ? int'(busy0) : int'(busy8);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (sel0 ? done0 : done8) begin
            edges = i;
            break;
         end
         bcnt += sel0 ? int'(busy0) : int'(busy8);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy8, done8, root8, rem8} !== '0) begin
         errors++;
         $display("FAIL reset8: got busy=%0d done=%0d root=%0d rem=%0d expected all 0", busy8, done8, root8, rem8);
      end
      checks++;
      if ({busy0, done0, root0, rem0} !== '0) begin
         errors++;
         $display("FAIL reset0: got busy=%0d done=%0d root=%0d rem=%0d expected all 0", busy0, done0, root0, rem0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int e, b;
      start_op(1'b0, 8'd4, 1'b0);
      wait_done(1'b0, e, b);
      checks++;
      if (e !== 13) begin errors++; $display("FAIL latency4: got %0d edges expected 13", e); end
      checks++;
      if (b !== 12) begin errors++; $display("FAIL busy_len4: got %0d cycles expected 12", b); end
      checks++;
      if (root8 !== 12'h200 || rem8 !== 13'd0) begin
         errors++; $display("FAIL sqrt4: got root=%0h rem=%0d expected root=200 rem=0", root8, rem8);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0) begin errors++; $display("FAIL done_pulse: got done=%0d expected 0", done8); end
   endtask

   task automatic test_round();
      int e, b;
      start_op(1'b0, 8'd2, 1'b1);
      wait_done(1'b0, e, b);
      checks++;
      if (e !== 13 || root8 !== 12'd362 || rem8 !== 13'd28) begin
         errors++; $display("FAIL sqrt2_rnd: got edges=%0d root=%0d rem=%0d expected 13 362 28", e, root8, rem8);
      end
      start_op(1'b0, 8'd255, 1'b1);
      wait_done(1'b0, e, b);
      checks++;
      if (root8 !== 12'hFF8 || rem8 !== 13'd8111) begin
         errors++; $display("FAIL sqrt255_rnd: got root=%0h rem=%0d expected FF8 8111", root8, rem8);
      end
      start_op(1'b0, 8'd255, 1'b0);
      wait_done(1'b0, e, b);
      checks++;
      if (root8 !== 12'hFF7 || rem8 !== 13'd8111) begin
         errors++; $display("FAIL sqrt255_trunc: got root=%0h rem=%0d expected FF7 8111", root8, rem8);
      end
   endtask

   task automatic test_frac0();
      int e, b;
      start_op(1'b1, 8'd255, 1'b1);
      wait_done(1'b1, e, b);
      checks++;
      if (e !== 5 || b !== 4) begin
         errors++; $display("FAIL latency_f0: got edges=%0d busy=%0d expected 5 4", e, b);
      end
      checks++;
      if (root0 !== 4'd15 || rem0 !== 5'd30) begin
         errors++; $display("FAIL sat_f0: got root=%0d rem=%0d expected 15 30", root0, rem0);
      end
      start_op(1'b1, 8'd16, 1'b0);
      wait_done(1'b1, e, b);
      checks++;
      if (root0 !== 4'd4 || rem0 !== 5'd0) begin
         errors++; $display("FAIL sqrt16_f0: got root=%0d rem=%0d expected 4 0", root0, rem0);
      end
   endtask

   task automatic test_back_to_back();
      int e, b;
      e = -1;
      start_op(1'b0, 8'd255, 1'b0);
      // A start pulse mid-run must not disturb the operation in flight.
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 3) begin start8 = 1'b1; din8 = 8'd9; end
         if (i == 4) start8 = 1'b0;
         if (done8) begin e = i; break; end
      end
      checks++;
      if (e !== 13 || root8 !== 12'hFF7 || rem8 !== 13'd8111) begin
         errors++; $display("FAIL busy_ignore: got edges=%0d root=%0h rem=%0d expected 13 FF7 8111", e, root8, rem8);
      end
      // Start held in the done cycle is accepted.
      din8 = 8'd0; rnd8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || root8 !== 12'hFF7 || rem8 !== 13'd8111) begin
         errors++; $display("FAIL b2b_accept_hold: got busy=%0d root=%0h rem=%0d expected 1 FF7 8111", busy8, root8, rem8);
      end
      wait_done(1'b0, e, b);
      checks++;
      if (e !== 13 || root8 !== 12'd0 || rem8 !== 13'd0) begin
         errors++; $display("FAIL b2b_zero: got edges=%0d root=%0d rem=%0d expected 13 0 0", e, root8, rem8);
      end
   endtask

   task automatic test_reset_mid();
      int e, b, seen;
      start_op(1'b0, 8'd4, 1'b0);
      wait_done(1'b0, e, b);
      start_op(1'b0, 8'd255, 1'b1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || root8 !== 12'd0 || rem8 !== 13'd0) begin
         errors++; $display("FAIL reset_mid: got busy=%0d done=%0d root=%0h rem=%0d expected 0 0 0 0", busy8, done8, root8, rem8);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done8) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", seen); end
      start_op(1'b0, 8'd2, 1'b1);
      wait_done(1'b0, e, b);
      checks++;
      if (e !== 13 || root8 !== 12'd362 || rem8 !== 13'd28) begin
         errors++; $display("FAIL after_reset: got edges=%0d root=%0d rem=%0d expected 13 362 28", e, root8, rem8);
      end
   endtask

   initial begin
      start8 = 1'b0; rnd8 = 1'b0; din8 = '0;
      start0 = 1'b0; rnd0 = 1'b0; din0 = '0;
      test_reset();
      test_basic();
      test_round();
      test_frac0();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
